// File: rtl/branch_redirect_select_pkg.sv
// Shared backend definitions: ROB age ordering and the branch redirect payload.
// ROB indices carry a wrap (direction) bit above the index so age compares survive one ROB wrap.
package branch_redirect_select_pkg;

  localparam int DEF_ROB_WIDTH   = 6;
  localparam int DEF_FSQ_WIDTH   = 5;
  localparam int DEF_VADDR_WIDTH = 39;
  localparam int ROB_IDX_MAX_W   = 16;

  typedef struct packed {
    logic                     dir;
    logic [DEF_ROB_WIDTH-1:0] idx;
  } rob_idx_t;

  typedef struct packed {
    rob_idx_t                   rob_idx;
    logic [DEF_FSQ_WIDTH-1:0]   fsq_idx;
    logic [DEF_VADDR_WIDTH-1:0] target;
    logic                       taken;
    logic [1:0]                 br_type;
    logic [1:0]                 ras_type;
  } branch_redirect_t;

  // Strictly older; equal entries are not older. Callers zero-extend idx to ROB_IDX_MAX_W.
  function automatic logic older(input logic                     a_dir,
                                 input logic [ROB_IDX_MAX_W-1:0] a_idx,
                                 input logic                     b_dir,
                                 input logic [ROB_IDX_MAX_W-1:0] b_idx);
    return (a_dir == b_dir) ? (a_idx < b_idx) : (a_idx > b_idx);
  endfunction

endpackage

// File: rtl/branch_redirect_select_rob_age_select.sv
// Oldest-of-N selector: a pairwise tree over valid lanes returning the winning lane.
// Left (lower-numbered) subtrees win ties, so equal indices resolve to the lowest lane.
module rob_age_select
  import branch_redirect_select_pkg::*;
#(
  parameter int N         = 2,
  parameter int ROB_WIDTH = DEF_ROB_WIDTH,
  localparam int LW       = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]             valid,
  input  logic [N*(ROB_WIDTH+1)-1:0] rob_idx,
  output logic                     sel_valid,
  output logic [LW-1:0]            sel_lane,
  output logic [ROB_WIDTH:0]       sel_rob_idx
);

  localparam int RW   = ROB_WIDTH + 1;
  localparam int LVLS = (N > 1) ? $clog2(N) : 0;
  localparam int NP   = 1 << LVLS;

  function automatic logic is_older(input logic [RW-1:0] a, input logic [RW-1:0] b);
    return older(a[RW-1], ROB_IDX_MAX_W'(a[RW-2:0]), b[RW-1], ROB_IDX_MAX_W'(b[RW-2:0]));
  endfunction

  // Heap-ordered tree: leaves at NP..2*NP-1, node k merges children 2k and 2k+1.
  always_comb begin : tree
    logic          nv [1:2*NP-1];
    logic [LW-1:0] nl [1:2*NP-1];
    logic [RW-1:0] nr [1:2*NP-1];
    for (int k = 1; k < 2*NP; k++) begin
      nv[k] = 1'b0;
      nl[k] = '0;
      nr[k] = '0;
    end
    for (int i = 0; i < N; i++) begin
      nv[NP+i] = valid[i];
      nl[NP+i] = LW'(i);
      nr[NP+i] = rob_idx[i*RW +: RW];
    end
    for (int k = NP - 1; k >= 1; k--) begin
      if (nv[2*k+1] && (!nv[2*k] || is_older(nr[2*k+1], nr[2*k]))) begin
        nv[k] = 1'b1;
        nl[k] = nl[2*k+1];
        nr[k] = nr[2*k+1];
      end else begin
        nv[k] = nv[2*k];
        nl[k] = nl[2*k];
        nr[k] = nr[2*k];
      end
    end
    sel_valid   = nv[1];
    sel_lane    = nl[1];
    sel_rob_idx = nr[1];
  end

endmodule

// File: rtl/branch_redirect_select.sv
// Picks the oldest live branch-mispredict report, registers it as the branch redirect,
// and tracks a kill index so younger wrong-path reports are dropped until recovery.
module branch_redirect_select
  import branch_redirect_select_pkg::*;
#(
  parameter int BRU_NUM     = 2,
  parameter int ROB_WIDTH   = DEF_ROB_WIDTH,
  parameter int FSQ_WIDTH   = DEF_FSQ_WIDTH,
  parameter int VADDR_WIDTH = DEF_VADDR_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [BRU_NUM-1:0]               bru_en,
  input  logic [BRU_NUM*(ROB_WIDTH+1)-1:0] bru_rob_idx,
  input  logic [BRU_NUM*FSQ_WIDTH-1:0]     bru_fsq_idx,
  input  logic [BRU_NUM*VADDR_WIDTH-1:0]   bru_target,
  input  logic [BRU_NUM-1:0]               bru_taken,
  input  logic [BRU_NUM*2-1:0]             bru_br_type,
  input  logic [BRU_NUM*2-1:0]             bru_ras_type,
  input  logic                             fb_redirect_en,
  input  logic [ROB_WIDTH:0]               fb_rob_idx,
  input  logic                             csr_flush,
  input  logic                             recover_done,
  output logic                             out_en,
  output logic [ROB_WIDTH:0]               out_rob_idx,
  output logic [FSQ_WIDTH-1:0]             out_fsq_idx,
  output logic [VADDR_WIDTH-1:0]           out_target,
  output logic                             out_taken,
  output logic [1:0]                       out_br_type,
  output logic [1:0]                       out_ras_type
);

  localparam int RW = ROB_WIDTH + 1;
  localparam int LW = (BRU_NUM > 1) ? $clog2(BRU_NUM) : 1;

  typedef struct packed {
    logic [RW-1:0]          rob_idx;
    logic [FSQ_WIDTH-1:0]   fsq_idx;
    logic [VADDR_WIDTH-1:0] target;
    logic                   taken;
    logic [1:0]             br_type;
    logic [1:0]             ras_type;
  } redirect_t;

  function automatic logic is_older(input logic [RW-1:0] a, input logic [RW-1:0] b);
    return older(a[RW-1], ROB_IDX_MAX_W'(a[RW-2:0]), b[RW-1], ROB_IDX_MAX_W'(b[RW-2:0]));
  endfunction

  redirect_t     lane_pl [BRU_NUM];
  logic [BRU_NUM-1:0] live;
  logic          sel_valid;
  logic [LW-1:0] sel_lane;
  logic [RW-1:0] sel_rob_idx;

  logic          out_en_d, out_en_q;
  redirect_t     out_d, out_q;
  logic          kill_valid_d, kill_valid_q;
  logic [RW-1:0] kill_idx_d, kill_idx_q;

  always_comb begin
    for (int i = 0; i < BRU_NUM; i++) begin
      lane_pl[i].rob_idx  = bru_rob_idx[i*RW +: RW];
      lane_pl[i].fsq_idx  = bru_fsq_idx[i*FSQ_WIDTH +: FSQ_WIDTH];
      lane_pl[i].target   = bru_target[i*VADDR_WIDTH +: VADDR_WIDTH];
      lane_pl[i].taken    = bru_taken[i];
      lane_pl[i].br_type  = bru_br_type[i*2 +: 2];
      lane_pl[i].ras_type = bru_ras_type[i*2 +: 2];
    end
  end

  // A report equal to the kill index is the redirect already in flight, so it is dropped too.
  always_comb begin
    for (int i = 0; i < BRU_NUM; i++) begin
      live[i] = bru_en[i] & ~csr_flush &
                (~kill_valid_q | is_older(lane_pl[i].rob_idx, kill_idx_q));
    end
  end

  rob_age_select #(
    .N         (BRU_NUM),
    .ROB_WIDTH (ROB_WIDTH)
  ) u_age_select (
    .valid       (live),
    .rob_idx     (bru_rob_idx),
    .sel_valid   (sel_valid),
    .sel_lane    (sel_lane),
    .sel_rob_idx (sel_rob_idx)
  );

  // On recover_done the old kill is retired; same-cycle reports re-seed it since they
  // were already filtered against the old value.
  always_comb begin
    kill_valid_d = 1'b0;
    kill_idx_d   = kill_idx_q;
    if (kill_valid_q && !recover_done) begin
      kill_valid_d = 1'b1;
      kill_idx_d   = kill_idx_q;
    end
    if (fb_redirect_en && (!kill_valid_d || is_older(fb_rob_idx, kill_idx_d))) begin
      kill_valid_d = 1'b1;
      kill_idx_d   = fb_rob_idx;
    end
    if (sel_valid && (!kill_valid_d || is_older(sel_rob_idx, kill_idx_d))) begin
      kill_valid_d = 1'b1;
      kill_idx_d   = sel_rob_idx;
    end
    if (csr_flush) begin
      kill_valid_d = 1'b0;
      kill_idx_d   = kill_idx_q;
    end
  end

  always_comb begin
    out_en_d = sel_valid;
    out_d    = sel_valid ? lane_pl[sel_lane] : out_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_en_q     <= 1'b0;
      out_q        <= '0;
      kill_valid_q <= 1'b0;
      kill_idx_q   <= '0;
    end else begin
      out_en_q     <= out_en_d;
      out_q        <= out_d;
      kill_valid_q <= kill_valid_d;
      kill_idx_q   <= kill_idx_d;
    end
  end

  assign out_en       = out_en_q;
  assign out_rob_idx  = out_q.rob_idx;
  assign out_fsq_idx  = out_q.fsq_idx;
  assign out_target   = out_q.target;
  assign out_taken    = out_q.taken;
  assign out_br_type  = out_q.br_type;
  assign out_ras_type = out_q.ras_type;

endmodule

// File: tb/tb_branch_redirect_select.sv
// Directed, table-driven bench for branch_redirect_select with a few hand-written
// sequences for payload hold and mid-stream reset.
module tb_branch_redirect_select;

  localparam int BRU_NUM     = 2;
  localparam int ROB_WIDTH   = 6;
  localparam int FSQ_WIDTH   = 5;
  localparam int VADDR_WIDTH = 39;

  logic                             clk;
  logic                             rst;
  logic [BRU_NUM-1:0]               bru_en;
  logic [BRU_NUM*(ROB_WIDTH+1)-1:0] bru_rob_idx;
  logic [BRU_NUM*FSQ_WIDTH-1:0]     bru_fsq_idx;
  logic [BRU_NUM*VADDR_WIDTH-1:0]   bru_target;
  logic [BRU_NUM-1:0]               bru_taken;
  logic [BRU_NUM*2-1:0]             bru_br_type;
  logic [BRU_NUM*2-1:0]             bru_ras_type;
  logic                             fb_redirect_en;
  logic [ROB_WIDTH:0]               fb_rob_idx;
  logic                             csr_flush;
  logic                             recover_done;
  logic                             out_en;
  logic [ROB_WIDTH:0]               out_rob_idx;
  logic [FSQ_WIDTH-1:0]             out_fsq_idx;
  logic [VADDR_WIDTH-1:0]           out_target;
  logic                             out_taken;
  logic [1:0]                       out_br_type;
  logic [1:0]                       out_ras_type;

  // Fixed per-lane side payload, so the winning lane is visible in every field.
  logic [4:0] lane_fsq   [2];
  logic       lane_taken [2];
  logic [1:0] lane_br    [2];
  logic [1:0] lane_ras   [2];

  typedef struct {
    logic [1:0]  en;
    logic [6:0]  rob0;
    logic [6:0]  rob1;
    logic [38:0] tgt0;
    logic [38:0] tgt1;
    logic        fb_en;
    logic [6:0]  fb_rob;
    logic        csr;
    logic        rd;
    logic        exp_en;
    int          exp_lane;
    logic [6:0]  exp_rob;
    logic [38:0] exp_tgt;
    logic        exp_kv;
    logic [6:0]  exp_ki;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  branch_redirect_select #(
    .BRU_NUM     (BRU_NUM),
    .ROB_WIDTH   (ROB_WIDTH),
    .FSQ_WIDTH   (FSQ_WIDTH),
    .VADDR_WIDTH (VADDR_WIDTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .bru_en         (bru_en),
    .bru_rob_idx    (bru_rob_idx),
    .bru_fsq_idx    (bru_fsq_idx),
    .bru_target     (bru_target),
    .bru_taken      (bru_taken),
    .bru_br_type    (bru_br_type),
    .bru_ras_type   (bru_ras_type),
    .fb_redirect_en (fb_redirect_en),
    .fb_rob_idx     (fb_rob_idx),
    .csr_flush      (csr_flush),
    .recover_done   (recover_done),
    .out_en         (out_en),
    .out_rob_idx    (out_rob_idx),
    .out_fsq_idx    (out_fsq_idx),
    .out_target     (out_target),
    .out_taken      (out_taken),
    .out_br_type    (out_br_type),
    .out_ras_type   (out_ras_type)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] rb(input logic dir, input int idx);
    return {dir, 6'(idx)};
  endfunction

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic addVec(input logic [1:0] en, input logic [6:0] rob0, input logic [6:0] rob1,
                        input logic [38:0] tgt0, input logic [38:0] tgt1,
                        input logic fb_en, input logic [6:0] fb_rob, input logic csr,
                        input logic rd, input logic exp_en, input int exp_lane,
                        input logic [6:0] exp_rob, input logic [38:0] exp_tgt,
                        input logic exp_kv, input logic [6:0] exp_ki);
    vec_t v;
    v.en = en; v.rob0 = rob0; v.rob1 = rob1; v.tgt0 = tgt0; v.tgt1 = tgt1;
    v.fb_en = fb_en; v.fb_rob = fb_rob; v.csr = csr; v.rd = rd;
    v.exp_en = exp_en; v.exp_lane = exp_lane; v.exp_rob = exp_rob; v.exp_tgt = exp_tgt;
    v.exp_kv = exp_kv; v.exp_ki = exp_ki;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    bru_en         = v.en;
    bru_rob_idx    = {v.rob1, v.rob0};
    bru_target     = {v.tgt1, v.tgt0};
    fb_redirect_en = v.fb_en;
    fb_rob_idx     = v.fb_rob;
    csr_flush      = v.csr;
    recover_done   = v.rd;
  endtask

  task automatic driveIdle();
    bru_en         = '0;
    bru_rob_idx    = '0;
    bru_target     = '0;
    fb_redirect_en = 1'b0;
    fb_rob_idx     = '0;
    csr_flush      = 1'b0;
    recover_done   = 1'b0;
  endtask

  task automatic checkOutput(input vec_t v, input int row);
    checkVal($sformatf("row%0d out_en", row), 64'(out_en), 64'(v.exp_en));
    checkVal($sformatf("row%0d kill_valid", row), 64'(dut.kill_valid_q), 64'(v.exp_kv));
    if (v.exp_kv)
      checkVal($sformatf("row%0d kill_idx", row), 64'(dut.kill_idx_q), 64'(v.exp_ki));
    if (v.exp_en) begin
      checkVal($sformatf("row%0d out_rob_idx", row), 64'(out_rob_idx), 64'(v.exp_rob));
      checkVal($sformatf("row%0d out_target", row), 64'(out_target), 64'(v.exp_tgt));
      checkVal($sformatf("row%0d out_fsq_idx", row), 64'(out_fsq_idx), 64'(lane_fsq[v.exp_lane]));
      checkVal($sformatf("row%0d out_taken", row), 64'(out_taken), 64'(lane_taken[v.exp_lane]));
      checkVal($sformatf("row%0d out_br_type", row), 64'(out_br_type), 64'(lane_br[v.exp_lane]));
      checkVal($sformatf("row%0d out_ras_type", row), 64'(out_ras_type), 64'(lane_ras[v.exp_lane]));
    end
  endtask

  initial begin
    lane_fsq[0] = 5'h0A;  lane_fsq[1] = 5'h15;
    lane_taken[0] = 1'b1; lane_taken[1] = 1'b0;
    lane_br[0] = 2'b01;   lane_br[1] = 2'b10;
    lane_ras[0] = 2'b11;  lane_ras[1] = 2'b01;
    bru_fsq_idx  = {lane_fsq[1], lane_fsq[0]};
    bru_taken    = {lane_taken[1], lane_taken[0]};
    bru_br_type  = {lane_br[1], lane_br[0]};
    bru_ras_type = {lane_ras[1], lane_ras[0]};

    //     en     rob0       rob1        tgt0         tgt1         fb    fb_rob     csr   rd    exp_en lane exp_rob    exp_tgt      kv    ki
    addVec(2'b01, rb(0,5),  '0,         39'h1000,    '0,          1'b0, '0,        1'b0, 1'b0, 1'b1, 0, rb(0,5),  39'h1000,    1'b1, rb(0,5));
    addVec(2'b00, '0,       '0,         '0,          '0,          1'b0, '0,        1'b0, 1'b1, 1'b0, 0, '0,       '0,          1'b0, '0);
    addVec(2'b11, rb(0,9),  rb(0,3),    39'h2000,    39'h2100,    1'b0, '0,        1'b0, 1'b0, 1'b1, 1, rb(0,3),  39'h2100,    1'b1, rb(0,3));
    addVec(2'b00, '0,       '0,         '0,          '0,          1'b0, '0,        1'b0, 1'b1, 1'b0, 0, '0,       '0,          1'b0, '0);
    addVec(2'b11, rb(1,2),  rb(0,60),   39'h3000,    39'h3100,    1'b0, '0,        1'b0, 1'b0, 1'b1, 1, rb(0,60), 39'h3100,    1'b1, rb(0,60));
    addVec(2'b00, '0,       '0,         '0,          '0,          1'b0, '0,        1'b0, 1'b1, 1'b0, 0, '0,       '0,          1'b0, '0);
    addVec(2'b01, rb(0,10), '0,         39'h4000,    '0,          1'b0, '0,        1'b0, 1'b0, 1'b1, 0, rb(0,10), 39'h4000,    1'b1, rb(0,10));
    addVec(2'b10, '0,       rb(0,12),   '0,          39'h4400,    1'b0, '0,        1'b0, 1'b0, 1'b0, 0, '0,       '0,          1'b1, rb(0,10));
    addVec(2'b10, '0,       rb(0,8),    '0,          39'h4800,    1'b0, '0,        1'b0, 1'b0, 1'b1, 1, rb(0,8),  39'h4800,    1'b1, rb(0,8));
    addVec(2'b00, '0,       '0,         '0,          '0,          1'b0, '0,        1'b0, 1'b1, 1'b0, 0, '0,       '0,          1'b0, '0);
    addVec(2'b00, '0,       '0,         '0,          '0,          1'b1, rb(0,4),   1'b0, 1'b0, 1'b0, 0, '0,       '0,          1'b1, rb(0,4));
    addVec(2'b01, rb(0,6),  '0,         39'h4A00,    '0,          1'b0, '0,        1'b0, 1'b0, 1'b0, 0, '0,       '0,          1'b1, rb(0,4));
    addVec(2'b01, rb(0,4),  '0,         39'h4B00,    '0,          1'b0, '0,        1'b0, 1'b0, 1'b0, 0, '0,       '0,          1'b1, rb(0,4));
    addVec(2'b01, rb(0,2),  '0,         39'h5000,    '0,          1'b0, '0,        1'b0, 1'b0, 1'b1, 0, rb(0,2),  39'h5000,    1'b1, rb(0,2));
    addVec(2'b00, '0,       '0,         '0,          '0,          1'b0, '0,        1'b0, 1'b1, 1'b0, 0, '0,       '0,          1'b0, '0);
    addVec(2'b01, rb(0,10), '0,         39'h6000,    '0,          1'b0, '0,        1'b0, 1'b0, 1'b1, 0, rb(0,10), 39'h6000,    1'b1, rb(0,10));
    addVec(2'b00, '0,       '0,         '0,          '0,          1'b0, '0,        1'b0, 1'b1, 1'b0, 0, '0,       '0,          1'b0, '0);
    addVec(2'b01, rb(0,20), '0,         39'h6800,    '0,          1'b0, '0,        1'b0, 1'b0, 1'b1, 0, rb(0,20), 39'h6800,    1'b1, rb(0,20));
    addVec(2'b00, '0,       '0,         '0,          '0,          1'b1, rb(0,25),  1'b0, 1'b1, 1'b0, 0, '0,       '0,          1'b1, rb(0,25));
    addVec(2'b00, '0,       '0,         '0,          '0,          1'b0, '0,        1'b0, 1'b1, 1'b0, 0, '0,       '0,          1'b0, '0);
    addVec(2'b00, '0,       '0,         '0,          '0,          1'b1, rb(0,40),  1'b0, 1'b0, 1'b0, 0, '0,       '0,          1'b1, rb(0,40));
    addVec(2'b01, rb(0,1),  '0,         39'hEEEE,    '0,          1'b0, '0,        1'b1, 1'b0, 1'b0, 0, '0,       '0,          1'b0, '0);
    addVec(2'b01, rb(1,3),  '0,         39'h8000,    '0,          1'b0, '0,        1'b0, 1'b0, 1'b1, 0, rb(1,3),  39'h8000,    1'b1, rb(1,3));
    addVec(2'b10, '0,       rb(0,50),   '0,          39'h8100,    1'b0, '0,        1'b0, 1'b0, 1'b1, 1, rb(0,50), 39'h8100,    1'b1, rb(0,50));
    addVec(2'b00, '0,       '0,         '0,          '0,          1'b0, '0,        1'b0, 1'b1, 1'b0, 0, '0,       '0,          1'b0, '0);
    addVec(2'b11, rb(0,7),  rb(0,7),    39'h9000,    39'h9100,    1'b0, '0,        1'b0, 1'b0, 1'b1, 0, rb(0,7),  39'h9000,    1'b1, rb(0,7));
    addVec(2'b01, rb(0,5),  '0,         39'hA000,    '0,          1'b1, rb(0,30),  1'b0, 1'b0, 1'b1, 0, rb(0,5),  39'hA000,    1'b1, rb(0,5));
    addVec(2'b10, '0,       rb(0,3),    '0,          39'hB100,    1'b1, rb(0,1),   1'b0, 1'b0, 1'b1, 1, rb(0,3),  39'hB100,    1'b1, rb(0,1));

    // Reset state
    rst = 1'b1;
    driveIdle();
    repeat (2) @(posedge clk);
    #1;
    checkVal("reset out_en", 64'(out_en), 64'd0);
    checkVal("reset out_rob_idx", 64'(out_rob_idx), 64'd0);
    checkVal("reset out_target", 64'(out_target), 64'd0);
    checkVal("reset out_fsq_idx", 64'(out_fsq_idx), 64'd0);
    checkVal("reset kill_valid", 64'(dut.kill_valid_q), 64'd0);
    checkVal("reset kill_idx", 64'(dut.kill_idx_q), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int r = 0; r < vecs.size(); r++) begin
      @(negedge clk);
      applyStimulus(vecs[r]);
      @(posedge clk);
      #1;
      checkOutput(vecs[r], r);
    end

    // Idle cycle: out_en drops, payload holds the last winner
    @(negedge clk);
    driveIdle();
    @(posedge clk);
    #1;
    checkVal("hold out_en", 64'(out_en), 64'd0);
    checkVal("hold out_rob_idx", 64'(out_rob_idx), 64'(rb(0,3)));
    checkVal("hold out_target", 64'(out_target), 64'h0000_B100);

    // Mid-stream reset clears a fresh selection without waiting for a clock edge
    @(negedge clk);
    bru_en      = 2'b01;
    bru_rob_idx = {7'd0, rb(0,0)};
    bru_target  = {39'd0, 39'hC000};
    @(posedge clk);
    #1;
    checkVal("pre-rst out_en", 64'(out_en), 64'd1);
    rst = 1'b1;
    #1;
    checkVal("async rst out_en", 64'(out_en), 64'd0);
    checkVal("async rst out_target", 64'(out_target), 64'd0);
    checkVal("async rst kill_valid", 64'(dut.kill_valid_q), 64'd0);
    @(negedge clk);
    rst         = 1'b0;
    bru_en      = 2'b01;
    bru_rob_idx = {7'd0, rb(0,33)};
    bru_target  = {39'd0, 39'hD000};
    @(posedge clk);
    #1;
    checkVal("post-rst out_en", 64'(out_en), 64'd1);
    checkVal("post-rst out_rob_idx", 64'(out_rob_idx), 64'(rb(0,33)));
    checkVal("post-rst out_target", 64'(out_target), 64'h0000_D000);
    checkVal("post-rst kill_idx", 64'(dut.kill_idx_q), 64'(rb(0,33)));
    @(negedge clk);
    driveIdle();
    @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
